// File: rtl/byte_stripe_pkg.sv
// byte_stripe_pkg
// Shared types for the transmit-side byte striper and for any model that
// un-stripes its lanes again.
//   DATA_W_DEF   : default byte / lane width
//   IDLE_W       : width of the collector idle counter (FLUSH_CYCLES <= 15)
//   coll_state_e : collector state, EMPTY (no byte held) / HALF (lane-0 byte held)
//   pair_t       : one frame worth of lane data {d0, d1, v0, v1}
package byte_stripe_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int IDLE_W     = 4;

  typedef enum logic {
    EMPTY = 1'b0,
    HALF  = 1'b1
  } coll_state_e;

  // Width is fixed to DATA_W_DEF; the striper is instantiated at that width.
  typedef struct packed {
    logic [DATA_W_DEF-1:0] d0;
    logic [DATA_W_DEF-1:0] d1;
    logic                  v0;
    logic                  v1;
  } pair_t;

endpackage

// File: rtl/byte_striping_if.sv
// byte_striping_if
// Byte stream in, two-lane frame out.
//   data_in / valid_in              : serial byte stream (no backpressure)
//   data_stripe_0/1, valid_stripe_0/1 : lane bytes, held for a whole frame
//   stripe_phase                    : frame phase, commit at end of phase 1
// Modports: master = byte source / lane sink side, slave = striper.
interface byte_striping_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] data_in;
  logic              valid_in;
  logic [DATA_W-1:0] data_stripe_0;
  logic [DATA_W-1:0] data_stripe_1;
  logic              valid_stripe_0;
  logic              valid_stripe_1;
  logic              stripe_phase;

  modport master (
    output data_in, valid_in,
    input  data_stripe_0, data_stripe_1, valid_stripe_0, valid_stripe_1,
           stripe_phase
  );

  modport slave (
    input  data_in, valid_in,
    output data_stripe_0, data_stripe_1, valid_stripe_0, valid_stripe_1,
           stripe_phase
  );
endinterface

// File: rtl/byte_striping.sv
// byte_striping
// Distributes a serial byte stream at clk_2f alternately onto two lanes
// (lane 0 first). Lane outputs only change on frame boundaries (every second
// clk_2f edge) so the serializers behind can sample them at clk_f.
// A lone lane-0 byte followed by FLUSH_CYCLES idle cycles is sent on its own.
// Ports:
//   clk_2f : sole clock, posedge
//   reset  : synchronous, active-high
//   bus    : byte_striping_if.slave (byte in, lanes/valids/phase out)
module byte_striping
  import byte_stripe_pkg::*;
#(
  parameter int DATA_W       = DATA_W_DEF,
  parameter int FLUSH_CYCLES = 3
) (
  input  logic             clk_2f,
  input  logic             reset,
  byte_striping_if.slave   bus
);

  localparam logic [IDLE_W-1:0] FLUSH_LAST = IDLE_W'(FLUSH_CYCLES - 1);

  logic                  phase_q,      phase_d;
  coll_state_e           state_q,      state_d;
  logic [DATA_W-1:0]     stage_0_q,    stage_0_d;
  logic [IDLE_W-1:0]     idle_cnt_q,   idle_cnt_d;
  pair_t                 pair_buf_q,   pair_buf_d;
  logic                  pair_valid_q, pair_valid_d;
  pair_t                 lanes_q,      lanes_d;

  logic                  pair_set;   // a complete (or flushed) pair forms this edge
  logic                  commit;     // this edge ends a frame

  // Collector: pairs consecutive bytes, or flushes a lone byte after idling.
  always_comb begin
    state_d    = state_q;
    stage_0_d  = stage_0_q;
    idle_cnt_d = idle_cnt_q;
    pair_buf_d = pair_buf_q;
    pair_set   = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (bus.valid_in) begin
          stage_0_d  = bus.data_in;
          idle_cnt_d = '0;
          state_d    = HALF;
        end
      end
      HALF: begin
        if (bus.valid_in) begin
          pair_buf_d = '{d0: stage_0_q, d1: bus.data_in, v0: 1'b1, v1: 1'b1};
          pair_set   = 1'b1;
          state_d    = EMPTY;
        end else if (idle_cnt_q == FLUSH_LAST) begin
          // Enough idle cycles: ship lane 0 alone; next byte restarts on lane 0.
          pair_buf_d = '{d0: stage_0_q, d1: '0, v0: 1'b1, v1: 1'b0};
          pair_set   = 1'b1;
          state_d    = EMPTY;
        end else begin
          idle_cnt_d = idle_cnt_q + 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // Frame commit. The commit reads the old pair_buf; a pair formed on the
  // same edge overwrites the buffer and keeps pair_valid set.
  always_comb begin
    phase_d = ~phase_q;
    commit  = phase_q;
    lanes_d = lanes_q;
    if (commit) begin
      if (pair_valid_q) begin
        lanes_d = pair_buf_q;
      end else begin
        lanes_d.v0 = 1'b0;
        lanes_d.v1 = 1'b0;
      end
    end
    pair_valid_d = pair_set | (pair_valid_q & ~commit);
  end

  always_ff @(posedge clk_2f) begin
    if (reset) begin
      phase_q      <= 1'b0;
      state_q      <= EMPTY;
      stage_0_q    <= '0;
      idle_cnt_q   <= '0;
      pair_buf_q   <= '0;
      pair_valid_q <= 1'b0;
      lanes_q      <= '0;
    end else begin
      phase_q      <= phase_d;
      state_q      <= state_d;
      stage_0_q    <= stage_0_d;
      idle_cnt_q   <= idle_cnt_d;
      pair_buf_q   <= pair_buf_d;
      pair_valid_q <= pair_valid_d;
      lanes_q      <= lanes_d;
    end
  end

  assign bus.data_stripe_0  = lanes_q.d0;
  assign bus.data_stripe_1  = lanes_q.d1;
  assign bus.valid_stripe_0 = lanes_q.v0;
  assign bus.valid_stripe_1 = lanes_q.v1;
  assign bus.stripe_phase   = phase_q;

endmodule
